comp_arbiter: RTL and testbench

//   Shares one WIDTH-bit magnitude comparator between N_REQ requesters.

---
 rtl/comp_arb_pkg.sv | 38 +++
 rtl/cmp_unit.sv | 16 +
 rtl/comp_arbiter.sv | 108 ++++++++++
 tb/tb_comp_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/comp_arb_pkg.sv
// Shared types and the round-robin pick helper for the shared-comparator arbiter.
package comp_arb_pkg;

    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned PTR_W   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StCmp,
        StResp
    } state_e;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_res_t;

    // First valid index scanning ptr, ptr+1, ... modulo n; 0 if none valid.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int unsigned        n);
        logic [PTR_W-1:0] pick;
        logic             found;
        int unsigned      idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = (32'(ptr) + i) % n;
            if (i < n && !found && valid[idx[PTR_W-1:0]]) begin
                pick  = idx[PTR_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/cmp_unit.sv
// Combinational unsigned magnitude comparator producing one-hot eq/gt/lt.
module cmp_unit
    import comp_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_res_t         res
);

    assign res.eq = (a == b);
    assign res.gt = (a > b);
    assign res.lt = (a < b);

endmodule

// File: rtl/comp_arbiter.sv
// Round-robin arbiter sharing one comparator among N_REQ requesters; results are
// returned with the owner's ID over a valid/ready response port.
module comp_arbiter
    import comp_arb_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_eq,
    output logic                   rsp_gt,
    output logic                   rsp_lt
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    cmp_res_t          res_q, res_d;
    cmp_res_t          cmp_res;
    logic [ID_W-1:0]   pick;
    logic              in_resp;

    assign pick = ID_W'(rr_pick(MAX_REQ'(req_valid), PTR_W'(rr_ptr_q), N_REQ));

    cmp_unit #(
        .WIDTH (WIDTH)
    ) u_cmp_unit (
        .a   (a_q),
        .b   (b_q),
        .res (cmp_res)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        req_ready = '0;
        unique case (state_q)
            StIdle: begin
                // Gate on rst so no grant is advertised while reset is held.
                if (|req_valid && !rst) begin
                    req_ready[pick] = 1'b1;
                    gnt_d           = pick;
                    a_d             = req_a[pick*WIDTH +: WIDTH];
                    b_d             = req_b[pick*WIDTH +: WIDTH];
                    state_d         = StCmp;
                end
            end
            StCmp: begin
                res_d   = cmp_res;
                id_d    = gnt_q;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d  = StIdle;
                    rr_ptr_d = (gnt_q == ID_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
        end
    end

    // Flags are only meaningful while a response is presented.
    assign in_resp   = (state_q == StResp);
    assign rsp_valid = in_resp;
    assign rsp_id    = id_q;
    assign rsp_eq    = res_q.eq & in_resp;
    assign rsp_gt    = res_q.gt & in_resp;
    assign rsp_lt    = res_q.lt & in_resp;

endmodule

// File: tb/tb_comp_arbiter.sv
// Directed, table-driven bench for comp_arbiter with WIDTH=4, N_REQ=4.
module tb_comp_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic        rsp_eq;
    logic        rsp_gt;
    logic        rsp_lt;

    int n_cmp = 0;
    int n_err = 0;

    comp_arbiter #(
        .WIDTH (4),
        .N_REQ (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_eq    (rsp_eq),
        .rsp_gt    (rsp_gt),
        .rsp_lt    (rsp_lt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  ready;
        logic [1:0]  id;
        logic [2:0]  flags;  // {eq, gt, lt}
    } vec_t;

    vec_t vecs[7];

    initial begin
        // Each vector runs from IDLE with rsp_ready=1; the round-robin pointer
        // carries over between vectors, so grants are hand-computed in order.
        vecs[0] = '{4'b0001, 16'h0009, 16'h0003, 4'b0001, 2'd0, 3'b010};
        vecs[1] = '{4'b0100, 16'h0F00, 16'h0000, 4'b0100, 2'd2, 3'b010};
        vecs[2] = '{4'b1010, 16'h0000, 16'h00F0, 4'b1000, 2'd3, 3'b100};
        vecs[3] = '{4'b1010, 16'h0000, 16'h00F0, 4'b0010, 2'd1, 3'b001};
        vecs[4] = '{4'b0001, 16'h0000, 16'h000F, 4'b0001, 2'd0, 3'b001};
        vecs[5] = '{4'b1111, 16'h7777, 16'h7777, 4'b0010, 2'd1, 3'b100};
        vecs[6] = '{4'b0001, 16'h000F, 16'h0000, 4'b0001, 2'd0, 3'b010};

        rst       = 1'b1;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        @(negedge clk);
        check("reset req_ready", 16'(req_ready), 16'h0);
        check("reset rsp_valid", 16'(rsp_valid), 16'h0);
        check("reset flags", 16'({rsp_eq, rsp_gt, rsp_lt}), 16'h0);
        check("reset rsp_id", 16'(rsp_id), 16'h0);

        step();
        rst       = 1'b0;
        req_valid = 4'h0;
        @(negedge clk);
        check("idle no req ready", 16'(req_ready), 16'h0);

        for (int i = 0; i < 7; i++) begin
            step();
            req_valid = vecs[i].valid;
            req_a     = vecs[i].a;
            req_b     = vecs[i].b;
            rsp_ready = 1'b1;
            @(negedge clk);
            check($sformatf("v%0d req_ready", i), 16'(req_ready), 16'(vecs[i].ready));
            check($sformatf("v%0d rsp_valid idle", i), 16'(rsp_valid), 16'h0);
            step();
            req_valid = 4'h0;
            @(negedge clk);
            check($sformatf("v%0d cmp rsp_valid", i), 16'(rsp_valid), 16'h0);
            check($sformatf("v%0d cmp req_ready", i), 16'(req_ready), 16'h0);
            step();
            @(negedge clk);
            check($sformatf("v%0d rsp_valid", i), 16'(rsp_valid), 16'h1);
            check($sformatf("v%0d rsp_id", i), 16'(rsp_id), 16'(vecs[i].id));
            check($sformatf("v%0d flags", i), 16'({rsp_eq, rsp_gt, rsp_lt}),
                  16'(vecs[i].flags));
            step();
            @(negedge clk);
            check($sformatf("v%0d back idle valid", i), 16'(rsp_valid), 16'h0);
            check($sformatf("v%0d back idle flags", i), 16'({rsp_eq, rsp_gt, rsp_lt}), 16'h0);
        end

        // Reset while the accepted request sits in the compare stage.
        step();
        req_valid = 4'b0001;
        req_a     = 16'h0009;
        req_b     = 16'h0003;
        @(negedge clk);
        check("rst-test grant", 16'(req_ready), 16'h1);
        step();
        req_valid = 4'h0;
        rst       = 1'b1;
        @(negedge clk);
        check("rst-in-cmp rsp_valid", 16'(rsp_valid), 16'h0);
        check("rst-in-cmp req_ready", 16'(req_ready), 16'h0);
        check("rst-in-cmp flags", 16'({rsp_eq, rsp_gt, rsp_lt}), 16'h0);
        check("rst-in-cmp rsp_id", 16'(rsp_id), 16'h0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("post-rst no rsp %0d", k), 16'(rsp_valid), 16'h0);
            step();
        end

        // All requesters valid, equal operands: pointer restarts at 0 after reset.
        req_valid = 4'hF;
        req_a     = 16'h5555;
        req_b     = 16'h5555;
        rsp_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            check($sformatf("rr c%0d req_ready", c), 16'(req_ready),
                  (c % 3 == 0) ? 16'(1 << ((c / 3) % 4)) : 16'h0);
            check($sformatf("rr c%0d rsp_valid", c), 16'(rsp_valid),
                  (c % 3 == 2) ? 16'h1 : 16'h0);
            if (c % 3 == 2) begin
                check($sformatf("rr c%0d rsp_id", c), 16'(rsp_id), 16'((c / 3) % 4));
                check($sformatf("rr c%0d flags", c), 16'({rsp_eq, rsp_gt, rsp_lt}), 16'h4);
            end
            step();
        end

        // Backpressure on requester 2's result; its valid stays high meanwhile.
        req_valid = 4'b0100;
        req_a     = 16'h0100;
        req_b     = 16'h0E00;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp grant", 16'(req_ready), 16'h4);
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp %0d rsp_valid", k), 16'(rsp_valid), 16'h1);
            check($sformatf("bp %0d rsp_id", k), 16'(rsp_id), 16'h2);
            check($sformatf("bp %0d flags", k), 16'({rsp_eq, rsp_gt, rsp_lt}), 16'h1);
            check($sformatf("bp %0d req_ready", k), 16'(req_ready), 16'h0);
            step();
        end
        req_valid = 4'h0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp held after valid drop", 16'(rsp_valid), 16'h1);
        step();
        @(negedge clk);
        check("bp accepted", 16'(rsp_valid), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
